fa_response_checker: RTL and testbench
======================================

FA_RESPONSE_CHECKER -- requirements
Module: fa_response_checker

Interface
REQ-001 Parameter ERR_CNT_W, default 8, SHALL set the width of the error counter.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  pulse that opens a check session; SHALL be honoured only in IDLE.
REQ-005 stop  input  1  forces the session to end; SHALL be honoured only in RUN.
REQ-006 vec_valid  input  1  stimulus/response tuple is present this cycle.
REQ-007 vec_ready  output  1  checker accepts a tuple this cycle.
REQ-008 a, b, cin  input  1 each  stimulus applied to the adder under check.
REQ-009 sum, cout  input  1 each  adder response to a/b/cin in the same cycle.
REQ-010 busy  output  1  high in RUN.
REQ-011 done  output  1  one-cycle pulse at session end.
REQ-012 pass  output  1  session verdict, held until the next start.
REQ-013 mismatch  output  1  one-cycle pulse per failing tuple.
REQ-014 err_count  output  ERR_CNT_W  failing-tuple count, saturating.
REQ-015 coverage  output  8  bit i set once vector index i = {a,b,cin} is accepted.
REQ-016 first_err_vec  output  3  index of the first failing tuple in the session.

Function
REQ-017 The FSM SHALL have three states, IDLE, RUN and DONE; IDLE->RUN on start, RUN->DONE on stop or on coverage becoming 8'hFF, DONE->IDLE unconditionally after one cycle.
REQ-018 On IDLE->RUN: err_count, coverage, first_err_vec and pass SHALL clear to 0.
REQ-019 vec_ready SHALL be 1 exactly when the state is RUN; a tuple is accepted when vec_valid && vec_ready.
REQ-020 Expected values: exp_sum = a^b^cin; exp_cout = majority(a,b,cin); a tuple fails if sum != exp_sum or cout != exp_cout.
REQ-021 Accept in cycle N: coverage, err_count, first_err_vec and mismatch SHALL reflect the tuple in cycle N+1 (latency 1).
REQ-022 err_count SHALL saturate at 2^ERR_CNT_W-1 and never wrap.
REQ-023 first_err_vec SHALL be captured only on the first failure of a session; later failures SHALL leave it unchanged.
REQ-024 Repeated vector indices SHALL be compared and counted, with coverage unchanged.
REQ-025 When the last missing coverage bit is set, the FSM SHALL enter DONE in the following cycle without further accepts.
REQ-026 When stop coincides with an accepted tuple, the tuple SHALL be checked and counted before DONE.
REQ-027 In DONE: done=1 for exactly one cycle, and pass SHALL be set to (coverage==8'hFF && err_count==0), using values that include the final tuple.
REQ-028 start in RUN or DONE and stop in IDLE or DONE SHALL be ignored; vec_valid outside RUN SHALL have no effect.
REQ-029 busy SHALL be 1 only in RUN; done and mismatch SHALL never be high while in IDLE except as the registered result of the preceding cycle.

Reset
REQ-030 On rst_n low, asynchronously: state=IDLE, vec_ready=0, busy=0, done=0, pass=0, mismatch=0, err_count=0, coverage=0, first_err_vec=0.
REQ-031 Reset asserted mid-session SHALL abandon the session without asserting done; after release the block SHALL wait in IDLE for start.

Structure
REQ-032 Package fa_chk_pkg SHALL hold the state enum, the 3-bit vector-index typedef and the VEC_ALL = 8'hFF constant.
REQ-033 The expected-value model SHALL be one combinational sub-module, fa_golden (inputs a, b, cin; outputs exp_sum, exp_cout).
REQ-034 The top level SHALL contain the FSM, the counters and the capture registers only; no clock gating and no latches.

Verification
REQ-035 Correct adder, all 8 vectors in order 0..7 -> done pulse one cycle after the tuple-7 update, pass=1, err_count=0, coverage=8'hFF.
REQ-036 sum inverted on vector 5 only -> mismatch pulse one cycle after the accept, err_count=1, first_err_vec=5, pass=0.
REQ-037 Vectors 0,1,2 then stop -> done=1, coverage=8'h07, pass=0.
REQ-038 ERR_CNT_W=2, all-wrong adder, 6 tuples with repeats and no full coverage, then stop -> err_count=3 (saturated), first_err_vec = first index sent.
REQ-039 rst_n low for 1 cycle mid-RUN after 4 tuples -> all outputs 0, no done pulse; start then restarts with coverage=0.
REQ-040 stop in the same cycle as an accepted tuple of vector 7 completing coverage, correct adder -> single done pulse, pass=1.

Source files
------------

// File: rtl/fa_chk_pkg.sv
// Shared types and constants for the full-adder response checker.
package fa_chk_pkg;

  localparam int unsigned VEC_N = 8;

  typedef logic [2:0] vec_idx_t;

  localparam logic [VEC_N-1:0] VEC_ALL = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/fa_golden.sv
// Reference full-adder model: the expected response for one stimulus tuple.
module fa_golden (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic exp_sum,
  output logic exp_cout
);

  assign exp_sum  = a ^ b ^ cin;
  assign exp_cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/fa_response_checker.sv
// Session-based checker comparing a full adder's responses against fa_golden,
// tracking vector coverage, a saturating error count and the first failing index.
module fa_response_checker
  import fa_chk_pkg::*;
#(
  parameter int unsigned ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 vec_valid,
  output logic                 vec_ready,
  input  logic                 a,
  input  logic                 b,
  input  logic                 cin,
  input  logic                 sum,
  input  logic                 cout,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic                 mismatch,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic [VEC_N-1:0]     coverage,
  output vec_idx_t             first_err_vec
);

  localparam logic [ERR_CNT_W-1:0] ERR_MAX = '1;

  state_t           state;
  state_t           state_d;
  vec_idx_t         idx;
  logic             exp_sum;
  logic             exp_cout;
  logic             accept;
  logic             fail;
  logic [VEC_N-1:0] cov_upd;

  fa_golden u_golden (
    .a        (a),
    .b        (b),
    .cin      (cin),
    .exp_sum  (exp_sum),
    .exp_cout (exp_cout)
  );

  assign idx     = {a, b, cin};
  assign accept  = (state == ST_RUN) && vec_valid;
  assign fail    = (sum != exp_sum) || (cout != exp_cout);
  assign cov_upd = coverage | (VEC_N'(1) << idx);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_d;
  end

  // Next state: completing coverage leaves RUN in the same edge as the final
  // accept so no further tuple can slip in.
  always_comb begin
    state_d = state;
    case (state)
      ST_IDLE: if (start) state_d = ST_RUN;
      ST_RUN:  if (stop || (accept && (cov_upd == VEC_ALL))) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Registered outputs, counters and capture registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec_ready     <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
      mismatch      <= 1'b0;
      err_count     <= '0;
      coverage      <= '0;
      first_err_vec <= '0;
    end else begin
      vec_ready <= (state_d == ST_RUN);
      busy      <= (state_d == ST_RUN);
      done      <= (state == ST_DONE);
      mismatch  <= accept && fail;
      if ((state == ST_IDLE) && start) begin
        pass          <= 1'b0;
        err_count     <= '0;
        coverage      <= '0;
        first_err_vec <= '0;
      end else begin
        if (accept) begin
          coverage <= cov_upd;
          if (fail) begin
            // err_count is zero only before the first failure of a session
            if (err_count == '0)     first_err_vec <= idx;
            if (err_count != ERR_MAX) err_count    <= err_count + ERR_CNT_W'(1);
          end
        end
        if (state == ST_DONE) pass <= (coverage == VEC_ALL) && (err_count == '0);
      end
    end
  end

endmodule

// File: tb/tb_fa_response_checker.sv
// Directed self-checking bench for fa_response_checker (default and 2-bit counter builds).
module tb_fa_response_checker;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0, stop = 1'b0, vec_valid = 1'b0;
  logic       a = 1'b0, b = 1'b0, cin = 1'b0, sum = 1'b0, cout = 1'b0;
  logic       vec_ready, busy, done, pass, mismatch;
  logic [7:0] err_count, coverage;
  logic [2:0] first_err_vec;
  logic       vec_ready2, busy2, done2, pass2, mismatch2;
  logic [1:0] err_count2;
  logic [7:0] coverage2;
  logic [2:0] first_err_vec2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fa_response_checker dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .vec_valid(vec_valid),
    .vec_ready(vec_ready), .a(a), .b(b), .cin(cin), .sum(sum), .cout(cout),
    .busy(busy), .done(done), .pass(pass), .mismatch(mismatch),
    .err_count(err_count), .coverage(coverage), .first_err_vec(first_err_vec)
  );

  fa_response_checker #(.ERR_CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .vec_valid(vec_valid),
    .vec_ready(vec_ready2), .a(a), .b(b), .cin(cin), .sum(sum), .cout(cout),
    .busy(busy2), .done(done2), .pass(pass2), .mismatch(mismatch2),
    .err_count(err_count2), .coverage(coverage2), .first_err_vec(first_err_vec2)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  // Present tuple v with an adder response, optionally corrupted.
  task automatic drive(input logic [2:0] v, input logic bad_sum, input logic bad_cout);
    {a, b, cin} = v;
    sum  = (v[2] ^ v[1] ^ v[0]) ^ bad_sum;
    cout = ((v[2] & v[1]) | (v[2] & v[0]) | (v[1] & v[0])) ^ bad_cout;
    vec_valid = 1'b1;
  endtask

  task automatic open_session();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({vec_ready, busy, done, pass, mismatch, err_count, coverage, first_err_vec} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got=%0h exp=0",
               {vec_ready, busy, done, pass, mismatch, err_count, coverage, first_err_vec});
    end
    tick(); tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if ({vec_ready, busy} !== 2'b00) begin
      failures++; $display("FAIL idle_after_reset got=%b exp=00", {vec_ready, busy});
    end
  endtask

  task automatic test_full_pass();
    open_session();
    checks++;
    if ({busy, vec_ready, coverage} !== {2'b11, 8'h00}) begin
      failures++; $display("FAIL run_entry got=%0h exp=300", {busy, vec_ready, coverage});
    end
    for (int i = 0; i < 8; i++) begin
      drive(3'(i), 1'b0, 1'b0);
      tick();
      checks++;
      if (mismatch !== 1'b0 || coverage !== 8'((16'h1 << (i + 1)) - 1)) begin
        failures++;
        $display("FAIL full_cov_%0d got=%0h/%b exp=%0h/0", i, coverage, mismatch,
                 8'((16'h1 << (i + 1)) - 1));
      end
    end
    vec_valid = 1'b0;
    checks++;
    if ({busy, vec_ready, done, err_count} !== {3'b000, 8'd0}) begin
      failures++; $display("FAIL full_in_done got=%0h exp=0", {busy, vec_ready, done, err_count});
    end
    tick();
    checks++;
    if ({done, pass} !== 2'b11) begin
      failures++; $display("FAIL full_done_pass got=%b exp=11", {done, pass});
    end
    tick();
    checks++;
    if ({done, pass} !== 2'b01) begin
      failures++; $display("FAIL full_pass_hold got=%b exp=01", {done, pass});
    end
  endtask

  task automatic test_single_error();
    open_session();
    checks++;
    if (pass !== 1'b0) begin
      failures++; $display("FAIL err_pass_clear got=%b exp=0", pass);
    end
    for (int i = 0; i < 8; i++) begin
      drive(3'(i), i == 5, 1'b0);
      tick();
      if (i == 5) begin
        checks++;
        if ({mismatch, err_count, first_err_vec} !== {1'b1, 8'd1, 3'd5}) begin
          failures++;
          $display("FAIL err_vec5 got=%b/%0d/%0d exp=1/1/5", mismatch, err_count, first_err_vec);
        end
      end else if (i == 6) begin
        checks++;
        if (mismatch !== 1'b0) begin
          failures++; $display("FAIL err_mismatch_pulse got=%b exp=0", mismatch);
        end
      end
    end
    vec_valid = 1'b0;
    tick();
    checks++;
    if ({done, pass, err_count, first_err_vec} !== {2'b10, 8'd1, 3'd5}) begin
      failures++;
      $display("FAIL err_verdict got=%b%b/%0d/%0d exp=10/1/5", done, pass, err_count, first_err_vec);
    end
    tick();
  endtask

  task automatic test_partial_stop();
    open_session();
    for (int i = 0; i < 3; i++) begin
      drive(3'(i), 1'b0, 1'b0);
      tick();
    end
    vec_valid = 1'b0;
    stop = 1'b1;
    tick();
    stop = 1'b0;
    tick();
    checks++;
    if ({done, pass, coverage} !== {2'b10, 8'h07}) begin
      failures++; $display("FAIL partial_stop got=%b%b/%0h exp=10/07", done, pass, coverage);
    end
    tick();
  endtask

  task automatic test_saturation();
    logic [2:0] seq [6];
    seq = '{3'd3, 3'd1, 3'd3, 3'd0, 3'd1, 3'd0};
    open_session();
    for (int i = 0; i < 6; i++) begin
      drive(seq[i], 1'b0, 1'b1);
      tick();
      checks++;
      if (err_count2 !== 2'((i + 1 > 3) ? 3 : i + 1) || mismatch2 !== 1'b1) begin
        failures++;
        $display("FAIL sat_count_%0d got=%0d/%b exp=%0d/1", i, err_count2, mismatch2,
                 (i + 1 > 3) ? 3 : i + 1);
      end
    end
    vec_valid = 1'b0;
    checks++;
    if ({first_err_vec2, coverage2, err_count, first_err_vec} !== {3'd3, 8'h0B, 8'd6, 3'd3}) begin
      failures++;
      $display("FAIL sat_capture got=%0d/%0h/%0d/%0d exp=3/0b/6/3",
               first_err_vec2, coverage2, err_count, first_err_vec);
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    tick();
    checks++;
    if ({done2, pass2, err_count2} !== {2'b10, 2'd3}) begin
      failures++; $display("FAIL sat_done got=%b%b/%0d exp=10/3", done2, pass2, err_count2);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    open_session();
    for (int i = 0; i < 4; i++) begin
      drive(3'(i), 1'b0, 1'b0);
      tick();
    end
    vec_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({vec_ready, busy, done, pass, mismatch, err_count, coverage, first_err_vec} !== '0) begin
      failures++;
      $display("FAIL mid_reset got=%0h exp=0",
               {vec_ready, busy, done, pass, mismatch, err_count, coverage, first_err_vec});
    end
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({done, busy} !== 2'b00) begin
        failures++; $display("FAIL mid_reset_idle_%0d got=%b exp=00", i, {done, busy});
      end
    end
    open_session();
    checks++;
    if ({busy, coverage} !== {1'b1, 8'h00}) begin
      failures++; $display("FAIL mid_reset_restart got=%b/%0h exp=1/00", busy, coverage);
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_ignored();
    drive(3'd4, 1'b1, 1'b0);
    tick();
    vec_valid = 1'b0;
    checks++;
    if ({mismatch, err_count, coverage, vec_ready} !== '0) begin
      failures++;
      $display("FAIL idle_valid got=%b/%0d/%0h/%b exp=0/0/0/0", mismatch, err_count, coverage, vec_ready);
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    tick();
    checks++;
    if ({busy, done} !== 2'b00) begin
      failures++; $display("FAIL idle_stop got=%b exp=00", {busy, done});
    end
    open_session();
    drive(3'd2, 1'b0, 1'b0);
    tick();
    vec_valid = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if ({busy, coverage} !== {1'b1, 8'h04}) begin
      failures++; $display("FAIL run_start got=%b/%0h exp=1/04", busy, coverage);
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if ({done, busy} !== 2'b10) begin
      failures++; $display("FAIL done_start got=%b exp=10", {done, busy});
    end
    tick();
    checks++;
    if ({done, busy} !== 2'b00) begin
      failures++; $display("FAIL done_start_idle got=%b exp=00", {done, busy});
    end
  endtask

  task automatic test_stop_coincide();
    int pulses = 0;
    open_session();
    for (int i = 0; i < 7; i++) begin
      drive(3'(i), 1'b0, 1'b0);
      tick();
    end
    drive(3'd7, 1'b0, 1'b0);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    vec_valid = 1'b0;
    checks++;
    if ({busy, coverage, err_count} !== {1'b0, 8'hFF, 8'd0}) begin
      failures++; $display("FAIL coincide_cov got=%b/%0h/%0d exp=0/ff/0", busy, coverage, err_count);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      if (done === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 1 || pass !== 1'b1) begin
      failures++; $display("FAIL coincide_done got=%0d/%b exp=1/1", pulses, pass);
    end
  endtask

  initial begin
    test_reset();
    test_full_pass();
    test_single_error();
    test_partial_stop();
    test_saturation();
    test_reset_mid();
    test_ignored();
    test_stop_coincide();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
